// File: rtl/bg_pkg.sv
// bg_pkg: shared definitions for the affine background walker.
//   bg_walk_state_t : line sequencer states (IDLE, WALK, DONE)
//   SCREEN_W        : pixels per scanline
//   ACC_W           : reference accumulator width (signed 20.8)
//   FRAC_W          : fixed-point fraction width
//   sext16()        : sign-extends a signed 8.8 affine parameter to ACC_W
package bg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } bg_walk_state_t;

    localparam int unsigned SCREEN_W = 240;
    localparam int unsigned ACC_W    = 28;
    localparam int unsigned FRAC_W   = 8;

    function automatic logic [ACC_W-1:0] sext16(input logic [15:0] v);
        return {{(ACC_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/bg_affine_accum.sv
// bg_affine_accum: loadable, step-adding accumulator (modulo 2^W).
//   clk_i, rst_i : clock, asynchronous active-high reset (clears to 0)
//   load_i       : load load_val_i (wins over step_i)
//   step_i       : add step_val_i
//   q_o          : registered value
//   d_o          : next-state value (what q_o becomes at the next edge)
module bg_affine_accum
    import bg_pkg::*;
#(
    parameter int unsigned W = ACC_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic [W-1:0] step_val_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] d_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (step_i) begin
            val_d = val_q + step_val_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;
    assign d_o = val_d;

endmodule

// File: rtl/bg_affine_walker.sv
// bg_affine_walker: per-scanline sequencer for an affine BG layer.
// Walks SCREEN_W pixels per line_start, stepping the texture reference by
// PA/PC per pixel and PB/PD per line, and emits texel x/y plus oob over a
// valid/ready handshake.
//   clock, reset        : clock, asynchronous active-high reset
//   ref_load, ref_x/y   : load the line reference point (signed 20.8)
//   pa, pb, pc, pd      : signed 8.8 affine parameters
//   hmax, vmax, wrap    : layer size minus one, display-overflow wrap
//   mosaic_h            : horizontal mosaic size minus one
//   line_start          : begin a scanline (ignored while busy)
//   pix_ready/pix_valid : pixel handshake; x, y, oob, pix_idx qualify it
//   busy, line_done     : walking/finishing, one-cycle end-of-line pulse
// Optional feature: define BG_AFFINE_MOSAIC_EN for horizontal mosaic.
module bg_affine_walker
    import bg_pkg::*;
#(
    parameter int unsigned SCREEN_W = bg_pkg::SCREEN_W,
    parameter int unsigned ACC_W    = bg_pkg::ACC_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ref_load,
    input  logic [ACC_W-1:0] ref_x,
    input  logic [ACC_W-1:0] ref_y,
    input  logic [15:0]      pa,
    input  logic [15:0]      pb,
    input  logic [15:0]      pc,
    input  logic [15:0]      pd,
    input  logic [9:0]       hmax,
    input  logic [9:0]       vmax,
    input  logic             wrap,
    input  logic [3:0]       mosaic_h,
    input  logic             line_start,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic             oob,
    output logic [7:0]       pix_idx,
    output logic             busy,
    output logic             line_done
);

    localparam int unsigned INT_W = ACC_W - FRAC_W;

    bg_walk_state_t state_q;
    logic       pix_valid_q, oob_q, busy_q, line_done_q;
    logic [9:0] x_q, y_q;
    logic [7:0] pix_idx_q;

    logic             start, accept, last, adv;
    logic [ACC_W-1:0] step_x, step_y;
    logic [ACC_W-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
    logic [ACC_W-1:0] lref_x_q, lref_y_q, lref_x_d, lref_y_d;
    logic [9:0]       tex_x, tex_y, x_d, y_d;
    logic             oob_x, oob_y, oob_d;

    assign start  = (state_q == IDLE) && line_start;
    assign accept = (state_q == WALK) && pix_ready;
    assign last   = (pix_idx_q == 8'(SCREEN_W - 1));

`ifdef BG_AFFINE_MOSAIC_EN
    logic [3:0]       mos_q;
    logic [ACC_W-1:0] mos_scale;

    // acc only moves once per mosaic block, so each move covers the whole
    // block width: pixels then read ref, ref, .., ref+(m+1)*pa, ...
    assign adv       = (mos_q == mosaic_h);
    assign mos_scale = {{(ACC_W-5){1'b0}}, ({1'b0, mosaic_h} + 5'd1)};
    assign step_x    = sext16(pa) * mos_scale;
    assign step_y    = sext16(pc) * mos_scale;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mos_q <= '0;
        end else if (start) begin
            mos_q <= '0;
        end else if (accept) begin
            mos_q <= (mos_q == mosaic_h) ? 4'd0 : mos_q + 4'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{acc_x_q, acc_y_q, lref_x_d, lref_y_d,
                         acc_x_d[FRAC_W-1:0], acc_y_d[FRAC_W-1:0]};
`else
    assign adv    = 1'b1;
    assign step_x = sext16(pa);
    assign step_y = sext16(pc);

    logic unused_ok;
    assign unused_ok = ^{mosaic_h, acc_x_q, acc_y_q, lref_x_d, lref_y_d,
                         acc_x_d[FRAC_W-1:0], acc_y_d[FRAC_W-1:0]};
`endif

    // Line reference: ref_load wins over the end-of-line PB/PD step.
    bg_affine_accum #(.W(ACC_W)) u_lref_x (
        .clk_i(clock), .rst_i(reset),
        .load_i(ref_load), .load_val_i(ref_x),
        .step_i(state_q == DONE), .step_val_i(sext16(pb)),
        .q_o(lref_x_q), .d_o(lref_x_d)
    );

    bg_affine_accum #(.W(ACC_W)) u_lref_y (
        .clk_i(clock), .rst_i(reset),
        .load_i(ref_load), .load_val_i(ref_y),
        .step_i(state_q == DONE), .step_val_i(sext16(pd)),
        .q_o(lref_y_q), .d_o(lref_y_d)
    );

    bg_affine_accum #(.W(ACC_W)) u_acc_x (
        .clk_i(clock), .rst_i(reset),
        .load_i(start), .load_val_i(lref_x_q),
        .step_i(accept && adv), .step_val_i(step_x),
        .q_o(acc_x_q), .d_o(acc_x_d)
    );

    bg_affine_accum #(.W(ACC_W)) u_acc_y (
        .clk_i(clock), .rst_i(reset),
        .load_i(start), .load_val_i(lref_y_q),
        .step_i(accept && adv), .step_val_i(step_y),
        .q_o(acc_y_q), .d_o(acc_y_d)
    );

    // Coordinates are derived from the accumulators' next state so the
    // registered x/y/oob line up with the pixel the accumulators now hold.
    always_comb begin
        tex_x = acc_x_d[FRAC_W +: 10];
        tex_y = acc_y_d[FRAC_W +: 10];
        oob_x = acc_x_d[ACC_W-1] || (acc_x_d[ACC_W-1:FRAC_W] > INT_W'(hmax));
        oob_y = acc_y_d[ACC_W-1] || (acc_y_d[ACC_W-1:FRAC_W] > INT_W'(vmax));
        x_d   = tex_x;
        y_d   = tex_y;
        oob_d = oob_x || oob_y;
        if (wrap) begin
            x_d   = tex_x & hmax;
            y_d   = tex_y & vmax;
            oob_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            oob_q       <= 1'b0;
            pix_idx_q   <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    line_done_q <= 1'b0;
                    if (line_start) begin
                        state_q     <= WALK;
                        busy_q      <= 1'b1;
                        pix_valid_q <= 1'b1;
                        pix_idx_q   <= '0;
                        x_q         <= x_d;
                        y_q         <= y_d;
                        oob_q       <= oob_d;
                    end
                end
                WALK: begin
                    if (pix_ready) begin
                        if (last) begin
                            state_q     <= DONE;
                            pix_valid_q <= 1'b0;
                            line_done_q <= 1'b1;
                        end else begin
                            pix_idx_q <= pix_idx_q + 8'd1;
                            x_q       <= x_d;
                            y_q       <= y_d;
                            oob_q     <= oob_d;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    line_done_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_valid = pix_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign oob       = oob_q;
    assign pix_idx   = pix_idx_q;
    assign busy      = busy_q;
    assign line_done = line_done_q;

endmodule

// File: doc/bg_affine_walker.md
# bg_affine_walker

Per-scanline sequencer for an affine (rotate/scale) background layer. On each line start it walks 240 screen pixels and steps the texture-space reference point by PA/PC per pixel and PB/PD per line. For each pixel it emits 10-bit texel coordinates plus an out-of-range flag, using a valid/ready handshake into the background fetch path. Sits between the BG affine register file and the `overflow_handler`/tile-fetch datapath.

## Interface
- `SCREEN_W`, 240, pixels per line
- `ACC_W`, 28, reference accumulator width (signed 20.8 fixed point)
- `clock` input 1, sole clock
- `reset` input 1, asynchronous, active-high
- `ref_load` input 1, pulse: load internal line reference from `ref_x`/`ref_y`
- `ref_x`, `ref_y` input 28 each, signed 20.8 reference point (BGxX/BGxY)
- `pa`, `pb`, `pc`, `pd` input 16 each, signed 8.8 affine parameters
- `hmax`, `vmax` input 10 each, layer size minus one (127/255/511/1023)
- `wrap` input 1, display-overflow bit: wrap coordinates instead of flagging out-of-range
- `mosaic_h` input 4, horizontal mosaic size minus one (used only with `BG_AFFINE_MOSAIC_EN`)
- `line_start` input 1, pulse: begin walking one scanline
- `pix_ready` input 1, downstream accepts the current pixel
- `pix_valid` output 1, `x`/`y`/`oob`/`pix_idx` are valid
- `x`, `y` output 10 each, texel coordinates
- `oob` output 1, coordinate outside 0..hmax / 0..vmax with `wrap`=0
- `pix_idx` output 8, screen column 0..239
- `busy` output 1, high in WALK or DONE
- `line_done` output 1, one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, WALK, DONE. Reset leaves the FSM in IDLE. All outputs reset to 0. `line_ref_x`/`line_ref_y`, `acc_x`/`acc_y` and the mosaic counter reset to 0.
- IDLE: on `line_start` copy `line_ref` into `acc`, clear `pix_idx`, go to WALK.
- WALK: `pix_valid`=1. On `pix_valid & pix_ready`:
  - `acc_x += sext(pa)`, `acc_y += sext(pc)`, `pix_idx++`.
  - If `pix_idx`==`SCREEN_W`-1, go to DONE instead.
- Without the handshake (`pix_ready`=0), every output holds stable.
- DONE: one cycle. `line_done`=1, `line_ref_x += sext(pb)`, `line_ref_y += sext(pd)`, then return to IDLE.
- Coordinate math:
  - `ix` = `acc_x[17:8]`. Negative when `acc_x[27]`=1. Out of range when negative or when `acc_x[27:8]` > `hmax`. Same rules for `y` with `vmax`.
  - `wrap`=1: `x` = `ix & hmax`, `oob`=0.
  - `wrap`=0: `x` = `ix` (truncated), `oob`=1 when either axis is out of range.
- All additions are modulo 2^28. Overflow is discarded silently.
- `ref_load` has priority over the DONE increment in the same cycle. `ref_load` during WALK updates `line_ref` only; the active `acc` is unaffected.
- `line_start` while `busy` is ignored, with no queueing.
- `reset` mid-line returns the FSM to IDLE immediately. No `line_done` is emitted.

## Timing
- `line_start` at cycle N gives `pix_valid`=1 with pixel 0 at N+1.
- With `pix_ready` held at 1, a line is 240 consecutive accepted cycles.
- `line_done` follows the last acceptance by one cycle. The next `line_start` is accepted one cycle later (in IDLE).
- `x`, `y`, `oob` are registered from `acc`, so the outputs are glitch-free.
- `oob` is produced in the same cycle as `x`/`y` with no extra latency.

## Configuration
- `BG_AFFINE_MOSAIC_EN` defined:
  - `acc` advances only when the mosaic counter equals `mosaic_h`. The counter counts accepted pixels and clears on wrap.
  - Coordinates therefore repeat for `mosaic_h`+1 columns. `pix_idx` still increments on every acceptance.
- `BG_AFFINE_MOSAIC_EN` undefined: `mosaic_h` is ignored, and `acc` advances on every acceptance.

## Structure
- Shared `bg_pkg` holds:
  - the state enum `bg_walk_state_t` {IDLE, WALK, DONE}
  - `SCREEN_W`, `ACC_W` and the fixed-point fraction width (8)
  - a sign-extend helper function for 16-to-28 bit extension
- One sub-module, `bg_affine_accum`: an `ACC_W` loadable, step-adding register with `load`/`step` enables. It is instantiated for `acc_x`, `acc_y`, `line_ref_x` and `line_ref_y`.

## Test plan
- Identity walk:
  - Setup: `ref`=0, `pa`=0x0100, `pc`=0, `hmax`=255, `pix_ready`=1.
  - Expected: `x`=0..239 on consecutive cycles, `y`=0, `oob`=0, `line_done` one cycle after pixel 239.
- Line stepping:
  - Setup: `pb`=0, `pd`=0x0100, three lines.
  - Expected: `y`=0, 1, 2 on successive lines. `ref_load` with `ref_y`=0x500 in the same cycle as DONE makes the next line `y`=5.
- Wrap vs oob:
  - Setup: `ref_x`=0xFFFFF00 (−1.0), `pa`=0x0100, `hmax`=127.
  - With `wrap`=0: pixel 0 has `oob`=1, pixel 1 has `x`=0 and `oob`=0, and pixel 129 has `oob`=1.
  - With `wrap`=1: `x`=127, 0, …, and pixel 129 has `x`=0.
- Backpressure:
  - Stimulus: toggle `pix_ready` randomly.
  - Expected: exactly 240 acceptances, outputs stable while stalled, and `pix_idx` gapless.
- Reset mid-line:
  - Stimulus: assert `reset` at pixel 100.
  - Expected: all outputs 0 asynchronously, no `line_done`. The next `line_start` walks from `ref`=0.
- Mosaic (macro on):
  - Setup: `mosaic_h`=3, `pa`=0x0100.
  - Expected: `x`=0,0,0,0,4,4,4,4,…
